wide_add_seq: RTL and testbench
===============================

Name: wide_add_seq

Overview:
- Multi-word add/subtract sequencer. It time-shares one WIDTH-bit parallel-prefix adder slice across WORDS chunks, so one operation produces a WIDTH*WORDS-bit result.
- It sits between an operand producer and a result consumer, with a valid/ready handshake on each side.
- Per cycle it sequences one chunk, least-significant first, and chains the carry through a register.
- It is used where a full-width prefix network is too large but serial-chunk latency is acceptable.

Parameters:
- WIDTH, 24, chunk width in bits; the width of the shared prefix adder slice.
- WORDS, 4, number of chunks per operation; full operand width is WIDTH*WORDS. Legal range is 2..16.
- IDXW, $clog2(WORDS), width of the chunk index counter (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush; abandons any operation in flight.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept an operand.
- in_a  in  WIDTH*WORDS  operand A, unsigned or two's complement.
- in_b  in  WIDTH*WORDS  operand B.
- in_sub  in  1  1 = compute A-B; 0 = compute A+B+in_cin.
- in_cin  in  1  carry-in; ignored when in_sub=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH*WORDS  result.
- out_cout  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- out_ovf  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, idx=0, carry=0. out_sum=0, out_cout=0, out_ovf=0, out_valid=0, in_ready=1, busy=0.
- Reset asserted mid-operation discards the operation; no out_valid follows.
- State IDLE:
  - in_ready=1.
  - On the in_valid&&in_ready edge: latch A; latch B' = in_sub ? ~in_b : in_b; carry = in_sub ? 1 : in_cin; idx=0; go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle, drive the slice with chunk idx of A and B' plus the carry register.
  - Write the slice sum into out_sum chunk idx; carry <= slice cout; idx <= idx+1.
  - When idx==WORDS-1: go to DONE. Capture out_cout = slice cout. Capture out_ovf = a_msb ^ b'_msb ^ sum_msb ^ cout, where the first three terms give the carry into the MSB.
- State DONE:
  - out_valid=1; in_ready=0.
  - On out_ready=1: go to IDLE and drop out_valid.
  - out_sum, out_cout and out_ovf stay stable until the next accept.
- Latency: out_valid rises exactly WORDS cycles after the accept edge.
- Minimum spacing between accept edges is WORDS+2 cycles. There is no bypass; in_ready stays low in DONE even when out_ready is high.
- Outputs are registered. out_sum chunks are written in place, so out_sum is only meaningful while out_valid=1.
- clr=1 at an edge forces IDLE, idx=0, out_valid=0. clr has priority over an accept in the same cycle; that request is not taken.
- The slice is purely combinational. The longest path is one WIDTH-bit prefix carry plus the operand muxes; there is no cross-chunk combinational chain.

Decomposition:
- Shared package wide_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the localparam default chunk width 24;
  - a function computing the signed-overflow bit.
- One sub-module: prefix_add_slice, combinational.
  - Inputs: a[WIDTH], b[WIDTH], cin. Outputs: sum[WIDTH], cout.
  - Implementation: generate/propagate prefix network with log2 levels of span 1,2,4,8,16; cin is folded in as the bit-0 generate.
  - The sequencer instantiates it exactly once.

Test Plan (WIDTH=24, WORDS=4, 96-bit; values are hex):
- Carry ripple across all chunks:
  - Stimulus: A=000000_FFFFFF_FFFFFF_FFFFFF, B=1, sub=0, cin=0.
  - Required: out_sum=000001_000000_000000_000000, cout=0, ovf=0, out_valid 4 cycles after accept.
- Subtraction borrow:
  - Stimulus: A=0, B=1, sub=1.
  - Required: out_sum=FFFFFF_FFFFFF_FFFFFF_FFFFFF, cout=0, ovf=0.
  - Then A=5, B=5, sub=1: out_sum=0, cout=1.
- Signed overflow:
  - Stimulus: A=7FFFFF_FFFFFF_FFFFFF_FFFFFF, B=1.
  - Required: out_sum=800000_000000_000000_000000, cout=0, ovf=1.
  - Then A=B=800000_000000_000000_000000: out_sum=0, cout=1, ovf=1.
- Backpressure:
  - Stimulus: out_ready held low 5 cycles in DONE.
  - Required: out_valid, out_sum and cout stable; in_ready=0; a new in_valid is not accepted until 1 cycle after the out handshake.
- Flush and reset mid-operation:
  - Stimulus: clr pulsed when idx=2.
  - Required: next cycle state=IDLE, in_ready=1, and no out_valid ever appears for that op.
  - Repeat with an rst_n pulse mid-RUN: outputs go to reset values immediately.
  - A following op (1+1) returns 2.
- Random regression: 10k random A, B, sub and cin values, checked against a reference 97-bit model; out_valid pulses must match accepts one-for-one.

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
package wide_add_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default width of the shared prefix adder slice.
    localparam int unsigned DEFAULT_WIDTH = 24;

    // Signed overflow: the first three terms recover the carry into the MSB,
    // which is then compared against the carry out of the MSB.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic sum_msb,
        input logic cout
    );
        return a_msb ^ b_msb ^ sum_msb ^ cout;
    endfunction

endpackage

// File: rtl/prefix_add_slice.sv
// Combinational WIDTH-bit parallel-prefix (Kogge-Stone style) adder slice.
// The carry-in is folded in as the generate of an extra bit below bit 0.
module prefix_add_slice
    import wide_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned N      = WIDTH + 1;
    localparam int unsigned LEVELS = $clog2(N);

    logic [N-1:0] g_bit;
    logic [N-1:0] p_bit;
    logic [N-1:0] g_grp;

    // Bit-level generate/propagate, with cin occupying position 0.
    always_comb begin
        g_bit = {a & b, cin};
        p_bit = {a ^ b, 1'b0};
    end

    // Prefix tree: level l combines each position with the one 2**l below it.
    always_comb begin
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] gn;
        logic [N-1:0] pn;
        int unsigned  span;
        g    = g_bit;
        p    = p_bit;
        gn   = '0;
        pn   = '0;
        span = 0;
        for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
            span = 32'd1 << lvl;
            gn   = g;
            pn   = p;
            for (int unsigned i = 0; i < N; i++) begin
                if (i >= span) begin
                    gn[i] = g[i] | (p[i] & g[i - span]);
                    pn[i] = p[i] & p[i - span];
                end
            end
            g = gn;
            p = pn;
        end
        g_grp = g;
    end

    // Group generate at position i is the carry into bit i of the operands.
    always_comb begin
        sum  = p_bit[WIDTH:1] ^ g_grp[WIDTH-1:0];
        cout = g_grp[WIDTH];
    end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-word add/subtract sequencer: one shared WIDTH-bit prefix slice is
// stepped across WORDS chunks, least-significant first, with a registered carry.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned WORDS = 4,
    parameter int unsigned IDXW  = $clog2(WORDS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] in_a,
    input  logic [WIDTH*WORDS-1:0] in_b,
    input  logic                   in_sub,
    input  logic                   in_cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] out_sum,
    output logic                   out_cout,
    output logic                   out_ovf,
    output logic                   busy
);

    state_t state;
    state_t state_next;

    logic [IDXW-1:0]             idx;
    logic                        carry;
    logic [WORDS-1:0][WIDTH-1:0] a_reg;
    logic [WORDS-1:0][WIDTH-1:0] b_reg;
    logic [WORDS-1:0][WIDTH-1:0] sum_reg;
    logic                        cout_reg;
    logic                        ovf_reg;

    logic [WIDTH-1:0] a_chunk;
    logic [WIDTH-1:0] b_chunk;
    logic [WIDTH-1:0] s_chunk;
    logic             s_cout;
    logic             last;

    // Select the current chunk of both operands for the shared slice.
    always_comb begin
        a_chunk = a_reg[idx];
        b_chunk = b_reg[idx];
        last    = (idx == IDXW'(WORDS - 1));
    end

    prefix_add_slice #(
        .WIDTH (WIDTH)
    ) u_slice (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .sum  (s_chunk),
        .cout (s_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clr wins over any accept or completion.
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid)  state_next = RUN;
                RUN:     if (last)      state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default:                state_next = IDLE;
            endcase
        end
    end

    // Operand capture, per-chunk sum write-back and final flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else if (clr) begin
            idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_sub ? ~in_b : in_b;
                        carry <= in_sub ? 1'b1 : in_cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx] <= s_chunk;
                    carry        <= s_cout;
                    if (last) begin
                        idx      <= '0;
                        cout_reg <= s_cout;
                        ovf_reg  <= signed_ovf(a_chunk[WIDTH-1], b_chunk[WIDTH-1],
                                               s_chunk[WIDTH-1], s_cout);
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and status outputs decode directly from the state register.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        out_sum   = sum_reg;
        out_cout  = cout_reg;
        out_ovf   = ovf_reg;
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (WIDTH=24, WORDS=4, 96-bit results).
module tb_wide_add_seq;

    localparam int unsigned W = 24;
    localparam int unsigned N = 4;
    localparam int unsigned T = W * N;

    typedef struct packed {
        logic [T-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [T-1:0] in_a;
    logic [T-1:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [T-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    wide_add_seq #(
        .WIDTH (W),
        .WORDS (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // Reference: 97-bit addition with classical signed-overflow rule.
    function automatic res_t model(input logic [T-1:0] a, input logic [T-1:0] b,
                                   input logic sub, input logic cin);
        logic [T-1:0] bb;
        logic [T:0]   r;
        res_t         e;
        bb     = sub ? ~b : b;
        r      = {1'b0, a} + {1'b0, bb} + {{T{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = r[T-1:0];
        e.cout = r[T];
        e.ovf  = (a[T-1] == bb[T-1]) && (r[T-1] != a[T-1]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [T-1:0] a, input logic [T-1:0] b,
                        input logic sub, input logic cin);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Bounded wait for out_valid; lat is cycles after the accept edge (20 = timeout).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
        #2;
        n_cmp++; if (out_sum !== '0)     begin n_bad++; $display("FAIL reset_sum: got %h expected 0", out_sum); end
        n_cmp++; if (out_cout !== 1'b0)  begin n_bad++; $display("FAIL reset_cout: got %b expected 0", out_cout); end
        n_cmp++; if (out_ovf !== 1'b0)   begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", out_ovf); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        #10 rst_n = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_idle: got in_ready=%b busy=%b expected 1/0", in_ready, busy);
        end
    endtask

    task automatic test_ripple();
        int   lat;
        res_t e;
        sb.push_back('{sum: 96'h000001_000000_000000_000000, cout: 1'b0, ovf: 1'b0});
        send(96'h000000_FFFFFF_FFFFFF_FFFFFF, 96'h1, 1'b0, 1'b0);
        wait_valid(lat);
        e = sb.pop_front();
        n_cmp++; if (lat != 4)            begin n_bad++; $display("FAIL ripple_latency: got %0d expected 4", lat); end
        n_cmp++; if (out_sum !== e.sum)   begin n_bad++; $display("FAIL ripple_sum: got %h expected %h", out_sum, e.sum); end
        n_cmp++; if (out_cout !== e.cout) begin n_bad++; $display("FAIL ripple_cout: got %b expected %b", out_cout, e.cout); end
        n_cmp++; if (out_ovf !== e.ovf)   begin n_bad++; $display("FAIL ripple_ovf: got %b expected %b", out_ovf, e.ovf); end
        handshake();
    endtask

    task automatic test_sub();
        logic [T-1:0] a_t [2];
        logic [T-1:0] b_t [2];
        int           lat;
        res_t         e;
        a_t[0] = 96'h0; b_t[0] = 96'h1;
        a_t[1] = 96'h5; b_t[1] = 96'h5;
        sb.push_back('{sum: 96'hFFFFFF_FFFFFF_FFFFFF_FFFFFF, cout: 1'b0, ovf: 1'b0});
        sb.push_back('{sum: 96'h0, cout: 1'b1, ovf: 1'b0});
        for (int i = 0; i < 2; i++) begin
            send(a_t[i], b_t[i], 1'b1, 1'b1);
            wait_valid(lat);
            e = sb.pop_front();
            n_cmp++; if (lat != 4)            begin n_bad++; $display("FAIL sub%0d_latency: got %0d expected 4", i, lat); end
            n_cmp++; if (out_sum !== e.sum)   begin n_bad++; $display("FAIL sub%0d_sum: got %h expected %h", i, out_sum, e.sum); end
            n_cmp++; if (out_cout !== e.cout) begin n_bad++; $display("FAIL sub%0d_cout: got %b expected %b", i, out_cout, e.cout); end
            n_cmp++; if (out_ovf !== e.ovf)   begin n_bad++; $display("FAIL sub%0d_ovf: got %b expected %b", i, out_ovf, e.ovf); end
            handshake();
        end
    endtask

    task automatic test_ovf();
        logic [T-1:0] a_t [2];
        logic [T-1:0] b_t [2];
        int           lat;
        res_t         e;
        a_t[0] = 96'h7FFFFF_FFFFFF_FFFFFF_FFFFFF; b_t[0] = 96'h1;
        a_t[1] = 96'h800000_000000_000000_000000; b_t[1] = 96'h800000_000000_000000_000000;
        sb.push_back('{sum: 96'h800000_000000_000000_000000, cout: 1'b0, ovf: 1'b1});
        sb.push_back('{sum: 96'h0, cout: 1'b1, ovf: 1'b1});
        for (int i = 0; i < 2; i++) begin
            send(a_t[i], b_t[i], 1'b0, 1'b0);
            wait_valid(lat);
            e = sb.pop_front();
            n_cmp++; if (lat != 4)            begin n_bad++; $display("FAIL ovf%0d_latency: got %0d expected 4", i, lat); end
            n_cmp++; if (out_sum !== e.sum)   begin n_bad++; $display("FAIL ovf%0d_sum: got %h expected %h", i, out_sum, e.sum); end
            n_cmp++; if (out_cout !== e.cout) begin n_bad++; $display("FAIL ovf%0d_cout: got %b expected %b", i, out_cout, e.cout); end
            n_cmp++; if (out_ovf !== e.ovf)   begin n_bad++; $display("FAIL ovf%0d_ovf: got %b expected %b", i, out_ovf, e.ovf); end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int           lat;
        res_t         e;
        logic [T-1:0] held_sum;
        logic         held_cout;
        sb.push_back(model(96'h123456_789ABC_DEF012_345678, 96'h0FEDCB_A98765_432100_FFFFFF, 1'b0, 1'b1));
        send(96'h123456_789ABC_DEF012_345678, 96'h0FEDCB_A98765_432100_FFFFFF, 1'b0, 1'b1);
        wait_valid(lat);
        n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL bp_latency: got %0d expected 4", lat); end
        held_sum  = out_sum;
        held_cout = out_cout;
        // A competing request waits while the result is held.
        in_a = 96'h1; in_b = 96'h2; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1)    begin n_bad++; $display("FAIL bp_valid_c%0d: got %b expected 1", c, out_valid); end
            n_cmp++; if (out_sum !== held_sum)  begin n_bad++; $display("FAIL bp_sum_c%0d: got %h expected %h", c, out_sum, held_sum); end
            n_cmp++; if (out_cout !== held_cout) begin n_bad++; $display("FAIL bp_cout_c%0d: got %b expected %b", c, out_cout, held_cout); end
            n_cmp++; if (in_ready !== 1'b0)     begin n_bad++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, in_ready); end
        end
        e = sb.pop_front();
        n_cmp++; if (out_sum !== e.sum)   begin n_bad++; $display("FAIL bp_sum: got %h expected %h", out_sum, e.sum); end
        n_cmp++; if (out_cout !== e.cout) begin n_bad++; $display("FAIL bp_cout: got %b expected %b", out_cout, e.cout); end
        n_cmp++; if (out_ovf !== e.ovf)   begin n_bad++; $display("FAIL bp_ovf: got %b expected %b", out_ovf, e.ovf); end
        handshake();
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_after_handshake: got valid=%b busy=%b in_ready=%b expected 0/0/1", out_valid, busy, in_ready);
        end
        sb.push_back(model(96'h1, 96'h2, 1'b0, 1'b0));
        tick();
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_next_accept: got busy=%b expected 1", busy); end
        wait_valid(lat);
        e = sb.pop_front();
        n_cmp++; if (lat != 4)          begin n_bad++; $display("FAIL bp_next_latency: got %0d expected 4", lat); end
        n_cmp++; if (out_sum !== e.sum) begin n_bad++; $display("FAIL bp_next_sum: got %h expected %h", out_sum, e.sum); end
        handshake();
    endtask

    task automatic test_flush();
        int   lat;
        logic seen;
        res_t e;
        send(96'h0ABCDE_123456_654321_0F0F0F, 96'h111111_222222_333333_444444, 1'b0, 1'b0);
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL clr_idle: got busy=%b in_ready=%b valid=%b expected 0/1/0", busy, in_ready, out_valid);
        end
        // clr and a request in the same cycle: the request is dropped.
        clr = 1'b1; in_a = 96'h3; in_b = 96'h4; in_valid = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL clr_priority: got busy=%b expected 0", busy); end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL clr_no_valid: got %b expected 0", seen); end

        send(96'h0ABCDE_123456_654321_0F0F0F, 96'h111111_222222_333333_444444, 1'b0, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_ctrl: got valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy);
        end
        n_cmp++; if (out_sum !== '0) begin n_bad++; $display("FAIL rst_mid_sum: got %h expected 0", out_sum); end
        n_cmp++; if (out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_flags: got cout=%b ovf=%b expected 0/0", out_cout, out_ovf);
        end
        #3 rst_n = 1'b1;
        tick();
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_no_valid: got %b expected 0", seen); end

        sb.push_back('{sum: 96'h2, cout: 1'b0, ovf: 1'b0});
        send(96'h1, 96'h1, 1'b0, 1'b0);
        wait_valid(lat);
        e = sb.pop_front();
        n_cmp++; if (lat != 4)            begin n_bad++; $display("FAIL after_flush_latency: got %0d expected 4", lat); end
        n_cmp++; if (out_sum !== e.sum)   begin n_bad++; $display("FAIL after_flush_sum: got %h expected %h", out_sum, e.sum); end
        n_cmp++; if (out_cout !== e.cout) begin n_bad++; $display("FAIL after_flush_cout: got %b expected %b", out_cout, e.cout); end
        handshake();
    endtask

    task automatic test_random();
        logic [T-1:0] a;
        logic [T-1:0] b;
        logic         sub;
        logic         cin;
        int           lat;
        int           accepts;
        int           valids;
        res_t         e;
        accepts   = 0;
        valids    = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            a   = {$urandom, $urandom, $urandom};
            b   = {$urandom, $urandom, $urandom};
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            // Occasionally force long carry/borrow chains.
            if ($urandom_range(0, 7) == 0) b = ~a;
            sb.push_back(model(a, b, sub, cin));
            send(a, b, sub, cin);
            accepts++;
            wait_valid(lat);
            if (lat < 20) valids++;
            e = sb.pop_front();
            n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL rand%0d_latency: got %0d expected 4", k, lat); end
            n_cmp++; if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf) begin
                n_bad++;
                $display("FAIL rand%0d_result: got %h/%b/%b expected %h/%b/%b (a=%h b=%h sub=%b cin=%b)",
                         k, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf, a, b, sub, cin);
            end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (valids != accepts) begin n_bad++; $display("FAIL rand_one_for_one: got %0d results expected %0d", valids, accepts); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rand_scoreboard_empty: got %0d entries expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_sub();
        test_ovf();
        test_backpressure();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
